cpu_bank_reg_wb_arbiter: RTL and testbench
==========================================

// Module: cpu_bank_reg_wb_arbiter
// PURPOSE
// - Shares the single write port of CPU_bank_reg between NUM_REQ writeback sources
//   (e.g. 0=ALU, 1=load unit, 2=multiplier) using round-robin arbitration with valid/ready.
// - Registers the granted write into one output stage that drives the bank write port.
// - Flags read hazards on ports a/b while a write to that register is still in flight.
// PARAMETERS
// - NUM_REQ  3   number of writeback requesters (2..8)
// - ADDR_W   3   register index width (matches bank write_reg/read_reg_*)
// - DATA_W   32  register data width
// PORTS
// - clock          in   1               system clock, rising edge
// - reset          in   1               synchronous, active-low: block resets when reset==0 at posedge
// - req_valid      in   NUM_REQ         requester i has a write pending
// - req_reg        in   NUM_REQ*ADDR_W  destination index, slice i
// - req_data       in   NUM_REQ*DATA_W  write data, slice i
// - req_ready      out  NUM_REQ         one-hot grant; the write is accepted when valid&ready
// - write_enable   out  1               to bank_reg_if.write_enable
// - write_reg      out  ADDR_W          to bank_reg_if.write_reg
// - write_data     out  DATA_W          to bank_reg_if.write_data
// - read_reg_a/b   in   ADDR_W          indices currently presented to bank read ports
// - hazard_a/b     out  1               read on port a/b would return stale data
// PROTOCOL AND ARBITRATION
// - Reset (reset==0): write_enable=0, write_reg=0, write_data=0, and the RR pointer is 0.
//   While reset is 0, req_ready and hazard_a/b are combinationally 0.
// - req_ready is combinational from req_valid and the RR pointer.
// - At most one bit of req_ready is set, and only on a requester with req_valid=1.
// - Round-robin search starts at index ptr and goes ptr, ptr+1, ... modulo NUM_REQ.
// - On an accepted write by requester g, ptr <= (g+1) mod NUM_REQ at the next posedge.
// - With no valid requester, ptr is held and req_ready=0.
// - An accepted write appears on write_* at the following posedge (latency 1).
// - write_enable is 1 for exactly one cycle per accepted write.
// - Back-to-back accepts are allowed, one per cycle at full throughput.
// - The output stage never stalls; the bank absorbs one write per cycle.
// - A requester not granted must hold valid/reg/data stable until granted.
//   The arbiter samples req_reg/req_data only in the accept cycle.
// - A single valid requester is granted in the same cycle regardless of ptr (no starvation).
// - With all NUM_REQ requesters valid continuously, each is granted once per NUM_REQ cycles.
// HAZARD RULES
// - hazard_a = (write_enable && write_reg==read_reg_a)
//   || (any i: req_valid[i] && req_reg[i]==read_reg_a). hazard_b is the same for read_reg_b.
// - Hazards are combinational and carry no extra latency.
// - Register index 0 has no special behaviour; it is written and hazarded like any other.
// - Simultaneous requests to the same destination are serialized in RR order.
//   The last one granted wins in the bank.
// - Reset asserted mid-stream drops the in-flight output-stage write (write_enable forced 0).
//   Requesters see no accept that cycle and must re-present after reset is released.
// STRUCTURE
// - Shared package cpu_pkg holds REG_ADDR_W and REG_DATA_W (3 and 32), plus the
//   wb_req_t struct {logic valid; logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data;}.
// - Sub-module cpu_rr_arbiter #(N) provides the combinational one-hot grant from req and
//   ptr and the grant index. The pointer register stays in the parent.
// - The parent contains the pointer register, the output stage register and the hazard comparators.
// TESTING (bench instantiates this block plus CPU_bank_reg; reads via read_data_a/b)
// - Reset: hold reset=0 for 2 cycles with req_valid=3'b111 -> req_ready=0, write_enable=0, hazards 0.
// - Single write: req 1 valid, reg=2, data=0x2 for 1 cycle -> req_ready[1]=1 that cycle,
//   write_enable=1/reg=2 next cycle, then bank reg 2 reads 0x00000002.
// - Contention: all 3 valid (regs 1,2,3, data 0x10,0x20,0x30) from ptr=0.
//   Required grants over cycles 0..2 are 0,1,2, and regs 1..3 then read 0x10/0x20/0x30.
// - Same destination: req0 and req2 both target reg 5 (0xAA and 0xBB) from ptr=0.
//   Required: req0 granted first, then req2, and reg 5 finally reads 0xBB.
// - Hazard: req1 valid with reg 4 while read_reg_a=4 and read_reg_b=1 -> hazard_a=1, hazard_b=0.
//   hazard_a stays 1 through the write_enable cycle and is 0 the cycle after.
// - Reset mid-op: accept req0 (reg 6, 0x55), then reset=0 on the next cycle.
//   Required: write_enable=0 and reg 6 keeps its prior value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the writeback request record.
package cpu_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/cpu_rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr, wrapping modulo N.
module cpu_rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_valid
);

    always_comb begin : search
        int idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

    assign grant_valid = |grant;

endmodule

// File: rtl/cpu_bank_reg_wb_arbiter.sv
// Round-robin share of the register bank write port among writeback sources,
// with one registered output stage and read-after-write hazard flags.
module cpu_bank_reg_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      write_enable,
    output logic [ADDR_W-1:0]         write_reg,
    output logic [DATA_W-1:0]         write_data,
    input  logic [ADDR_W-1:0]         read_reg_a,
    input  logic [ADDR_W-1:0]         read_reg_b,
    output logic                      hazard_a,
    output logic                      hazard_b
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic               accept;
    logic               we_q;
    logic [ADDR_W-1:0]  sel_reg;
    logic [DATA_W-1:0]  sel_data;

    cpu_rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready = reset ? grant : '0;
    assign accept    = reset & grant_valid;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr        <= '0;
            we_q       <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                write_reg  <= sel_reg;
                write_data <= sel_data;
                ptr        <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
        end
    end

    // Gating by reset drops a write already sitting in the output stage.
    assign write_enable = we_q & reset;

    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        if (reset) begin
            if (we_q && write_reg == read_reg_a) hazard_a = 1'b1;
            if (we_q && write_reg == read_reg_b) hazard_b = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_reg[i*ADDR_W +: ADDR_W] == read_reg_a) hazard_a = 1'b1;
                if (req_valid[i] && req_reg[i*ADDR_W +: ADDR_W] == read_reg_b) hazard_b = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bank_reg_wb_arbiter.sv
// Self-checking bench: arbiter plus a behavioural register bank, scoreboarded writes.
module tb_cpu_bank_reg_wb_arbiter;
    import cpu_pkg::*;

    localparam int N  = 3;
    localparam int AW = REG_ADDR_W;
    localparam int DW = REG_DATA_W;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_reg = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            write_enable;
    logic [AW-1:0]   write_reg;
    logic [DW-1:0]   write_data;
    logic [AW-1:0]   read_reg_a = '0;
    logic [AW-1:0]   read_reg_b = '0;
    logic            hazard_a;
    logic            hazard_b;

    cpu_bank_reg_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_reg      (req_reg),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .read_reg_a   (read_reg_a),
        .read_reg_b   (read_reg_b),
        .hazard_a     (hazard_a),
        .hazard_b     (hazard_b)
    );

    always #5 clock = ~clock;

    // Behavioural register bank standing in for the real one.
    logic [DW-1:0] bank [1<<AW];
    logic [DW-1:0] read_data_a;
    logic [DW-1:0] read_data_b;
    initial for (int i = 0; i < (1<<AW); i++) bank[i] = '0;
    always @(posedge clock) if (write_enable) bank[write_reg] <= write_data;
    assign read_data_a = bank[read_reg_a];
    assign read_data_b = bank[read_reg_b];

    int          compared   = 0;
    int          mismatched = 0;
    wb_req_t     expq[$];
    int          model_ptr  = 0;
    logic        pend_valid = 1'b0;
    logic [AW-1:0] pend_reg = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int rrPick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [N-1:0] v,
                                 input logic [N*AW-1:0] regs, input logic [N*DW-1:0] datas,
                                 input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        int            g;
        logic [N-1:0]  exp_ready;
        logic          exp_ha;
        logic          exp_hb;
        logic [AW-1:0] rr [N];
        logic [DW-1:0] dd [N];
        wb_req_t       e;
        @(negedge clock);
        reset      = rst;
        req_valid  = v;
        req_reg    = regs;
        req_data   = datas;
        read_reg_a = ra;
        read_reg_b = rb;
        #1;
        for (int i = 0; i < N; i++) begin
            rr[i] = regs[i*AW +: AW];
            dd[i] = datas[i*DW +: DW];
        end
        g = rst ? rrPick(v, model_ptr) : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_ha = rst && pend_valid && (pend_reg == ra);
        exp_hb = rst && pend_valid && (pend_reg == rb);
        for (int i = 0; i < N; i++) begin
            if (rst && v[i] && rr[i] == ra) exp_ha = 1'b1;
            if (rst && v[i] && rr[i] == rb) exp_hb = 1'b1;
        end
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        checkOutput("hazard_a", 64'(hazard_a), 64'(exp_ha));
        checkOutput("hazard_b", 64'(hazard_b), 64'(exp_hb));
        checkOutput("write_enable", 64'(write_enable), 64'(rst && pend_valid));
        if (write_enable) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_write", 64'(1), 64'(0));
            end else begin
                e = expq.pop_front();
                checkOutput("write_reg", 64'(write_reg), 64'(e.rd));
                checkOutput("write_data", 64'(write_data), 64'(e.data));
            end
        end
        if (!rst) begin
            model_ptr  = 0;
            pend_valid = 1'b0;
            expq.delete();
        end else begin
            pend_valid = (g >= 0);
            if (g >= 0) begin
                pend_reg = rr[g];
                expq.push_back('{valid: 1'b1, rd: rr[g], data: dd[g]});
                model_ptr = (g + 1) % N;
            end
        end
    endtask

    task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        applyStimulus(1'b1, '0, '0, '0, ra, rb);
    endtask

    initial begin
        logic [N-1:0] v;
        // Reset held with everything requesting: nothing granted, no hazards.
        applyStimulus(1'b0, 3'b111, {3'd3, 3'd2, 3'd1}, '0, 3'd1, 3'd2);
        applyStimulus(1'b0, 3'b111, {3'd3, 3'd2, 3'd1}, '0, 3'd1, 3'd2);
        idle(3'd0, 3'd0);
        checkOutput("reset_write_reg", 64'(write_reg), 64'(0));
        checkOutput("reset_write_data", 64'(write_data), 64'(0));

        // Single write from requester 1.
        applyStimulus(1'b1, 3'b010, {3'd0, 3'd2, 3'd0}, {32'h0, 32'h2, 32'h0}, 3'd2, 3'd0);
        idle(3'd2, 3'd0);
        idle(3'd2, 3'd0);
        checkOutput("single_bank_r2", 64'(read_data_a), 64'h2);

        // Contention from ptr=0: grants 0,1,2 with granted requesters dropping out.
        applyStimulus(1'b0, '0, '0, '0, 3'd0, 3'd0);
        v = 3'b111;
        for (int c = 0; c < N; c++) begin
            applyStimulus(1'b1, v, {3'd3, 3'd2, 3'd1}, {32'h30, 32'h20, 32'h10}, 3'd7, 3'd7);
            checkOutput("contention_order", 64'(req_ready), 64'(1 << c));
            v = v & ~req_ready;
        end
        idle(3'd1, 3'd2);
        idle(3'd1, 3'd2);
        checkOutput("bank_r1", 64'(read_data_a), 64'h10);
        checkOutput("bank_r2", 64'(read_data_b), 64'h20);
        idle(3'd3, 3'd0);
        checkOutput("bank_r3", 64'(read_data_a), 64'h30);

        // Same destination: req0 then req2, last one wins.
        applyStimulus(1'b1, 3'b101, {3'd5, 3'd0, 3'd5}, {32'hBB, 32'h0, 32'hAA}, 3'd5, 3'd0);
        checkOutput("same_dst_first", 64'(req_ready), 64'(3'b001));
        applyStimulus(1'b1, 3'b100, {3'd5, 3'd0, 3'd5}, {32'hBB, 32'h0, 32'hAA}, 3'd5, 3'd0);
        checkOutput("same_dst_second", 64'(req_ready), 64'(3'b100));
        idle(3'd5, 3'd0);
        idle(3'd5, 3'd0);
        checkOutput("bank_r5", 64'(read_data_a), 64'hBB);

        // Hazard window on port a across request, write and retire cycles.
        applyStimulus(1'b1, 3'b010, {3'd0, 3'd4, 3'd0}, {32'h0, 32'h44, 32'h0}, 3'd4, 3'd1);
        checkOutput("hazard_req", 64'({hazard_a, hazard_b}), 64'(2'b10));
        idle(3'd4, 3'd1);
        checkOutput("hazard_we", 64'(hazard_a), 64'(1));
        idle(3'd4, 3'd1);
        checkOutput("hazard_clear", 64'(hazard_a), 64'(0));

        // All requesters valid continuously: each granted once per N cycles.
        for (int c = 0; c < 2 * N; c++) begin
            applyStimulus(1'b1, 3'b111, {3'd3, 3'd2, 3'd1},
                          {32'(c + 16'h300), 32'(c + 16'h200), 32'(c + 16'h100)}, 3'd0, 3'd7);
        end
        idle(3'd0, 3'd0);
        idle(3'd0, 3'd0);

        // Reset arriving while a write sits in the output stage.
        applyStimulus(1'b1, 3'b100, {3'd6, 3'd0, 3'd0}, {32'h66, 32'h0, 32'h0}, 3'd6, 3'd0);
        idle(3'd6, 3'd0);
        idle(3'd6, 3'd0);
        applyStimulus(1'b1, 3'b001, {3'd0, 3'd0, 3'd6}, {32'h0, 32'h0, 32'h55}, 3'd6, 3'd0);
        applyStimulus(1'b0, '0, '0, '0, 3'd6, 3'd0);
        checkOutput("midreset_we", 64'(write_enable), 64'(0));
        idle(3'd6, 3'd0);
        checkOutput("midreset_bank_r6", 64'(read_data_a), 64'h66);
        checkOutput("midreset_write_reg", 64'(write_reg), 64'(0));
        checkOutput("scoreboard_drained", 64'(expq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
